// File: rtl/hpdcache_flush_walker.sv
// Flush-all sequencer: walks every directory set, hands each valid+dirty line to the
// flush controller ALLOC port, clears its dirty bit on acceptance, then waits for drain.
module hpdcache_flush_walker #(
  parameter int unsigned SETS      = 64,
  parameter int unsigned WAYS      = 4,
  parameter int unsigned TAG_WIDTH = 20,
  localparam int unsigned SetWidth = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_all_req_i,
  output logic                          flush_all_ready_o,
  output logic                          flush_all_done_o,
  output logic                          dir_rd_o,
  output logic [SetWidth-1:0]           dir_rd_set_o,
  input  logic                          dir_rd_gnt_i,
  input  logic [WAYS-1:0]               dir_valid_i,
  input  logic [WAYS-1:0]               dir_dirty_i,
  input  logic [WAYS*TAG_WIDTH-1:0]     dir_tag_i,
  output logic                          dir_clr_dirty_o,
  output logic [SetWidth-1:0]           dir_clr_set_o,
  output logic [WAYS-1:0]               dir_clr_way_o,
  output logic                          flush_alloc_o,
  input  logic                          flush_alloc_ready_i,
  output logic [TAG_WIDTH+SetWidth-1:0] flush_alloc_nline_o,
  output logic [WAYS-1:0]               flush_alloc_way_o,
  input  logic                          flush_empty_i
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StCheck = 3'd2;
  localparam logic [2:0] StEmit  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  localparam logic [SetWidth-1:0] LastSet = SetWidth'(SETS - 1);

  logic [2:0]                state_q, state_d;
  logic [SetWidth-1:0]       set_cnt_q, set_cnt_d;
  logic [WAYS-1:0]           pending_q, pending_d;
  logic [WAYS*TAG_WIDTH-1:0] tags_q, tags_d;

  logic [WAYS-1:0]      sel_oh;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic [WAYS-1:0]      check_pending;
  logic                 advance;

  // Lowest set bit of pending picks the way to emit.
  assign sel_oh        = pending_q & (~pending_q + WAYS'(1));
  assign check_pending = dir_valid_i & dir_dirty_i;

  always_comb begin
    sel_tag = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (sel_oh[w]) sel_tag = sel_tag | tags_q[w*TAG_WIDTH +: TAG_WIDTH];
    end
  end

  always_comb begin
    state_d             = state_q;
    set_cnt_d           = set_cnt_q;
    pending_d           = pending_q;
    tags_d              = tags_q;
    advance             = 1'b0;
    flush_all_ready_o   = 1'b0;
    flush_all_done_o    = 1'b0;
    dir_rd_o            = 1'b0;
    dir_rd_set_o        = '0;
    dir_clr_dirty_o     = 1'b0;
    dir_clr_set_o       = '0;
    dir_clr_way_o       = '0;
    flush_alloc_o       = 1'b0;
    flush_alloc_nline_o = '0;
    flush_alloc_way_o   = '0;

    case (state_q)
      StIdle: begin
        flush_all_ready_o = 1'b1;
        if (flush_all_req_i) begin
          set_cnt_d = '0;
          state_d   = StRead;
        end
      end
      StRead: begin
        dir_rd_o     = 1'b1;
        dir_rd_set_o = set_cnt_q;
        if (dir_rd_gnt_i) state_d = StCheck;
      end
      StCheck: begin
        pending_d = check_pending;
        tags_d    = dir_tag_i;
        if (|check_pending) state_d = StEmit;
        else                advance = 1'b1;
      end
      StEmit: begin
        flush_alloc_o       = 1'b1;
        flush_alloc_nline_o = {sel_tag, set_cnt_q};
        flush_alloc_way_o   = sel_oh;
        if (flush_alloc_ready_i) begin
          dir_clr_dirty_o = 1'b1;
          dir_clr_set_o   = set_cnt_q;
          dir_clr_way_o   = sel_oh;
          pending_d       = pending_q & ~sel_oh;
          if (pending_d == '0) advance = 1'b1;
        end
      end
      StDrain: begin
        flush_all_done_o = flush_empty_i;
        if (flush_empty_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The walk never wraps: the last set always hands over to the drain wait.
    if (advance) begin
      if (set_cnt_q == LastSet) begin
        state_d = StDrain;
      end else begin
        set_cnt_d = set_cnt_q + SetWidth'(1);
        state_d   = StRead;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      set_cnt_q <= '0;
      pending_q <= '0;
      tags_q    <= '0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      pending_q <= pending_d;
      tags_q    <= tags_d;
    end
  end

endmodule

// File: tb/tb_hpdcache_flush_walker.sv
// Scoreboard bench for hpdcache_flush_walker: a directory/flush-controller model feeds the
// walker, expected ALLOCs and set reads are queued per flush and popped by a monitor.
module tb_hpdcache_flush_walker;
  localparam int unsigned SETS = 4;
  localparam int unsigned WAYS = 2;
  localparam int unsigned TW   = 8;
  localparam int unsigned SW   = 2;
  localparam int unsigned NLW  = TW + SW;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                flush_all_req_i;
  logic                flush_all_ready_o;
  logic                flush_all_done_o;
  logic                dir_rd_o;
  logic [SW-1:0]       dir_rd_set_o;
  logic                dir_rd_gnt_i;
  logic [WAYS-1:0]     dir_valid_i;
  logic [WAYS-1:0]     dir_dirty_i;
  logic [WAYS*TW-1:0]  dir_tag_i;
  logic                dir_clr_dirty_o;
  logic [SW-1:0]       dir_clr_set_o;
  logic [WAYS-1:0]     dir_clr_way_o;
  logic                flush_alloc_o;
  logic                flush_alloc_ready_i;
  logic [NLW-1:0]      flush_alloc_nline_o;
  logic [WAYS-1:0]     flush_alloc_way_o;
  logic                flush_empty_i;

  hpdcache_flush_walker #(.SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TW)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_all_req_i     (flush_all_req_i),
    .flush_all_ready_o   (flush_all_ready_o),
    .flush_all_done_o    (flush_all_done_o),
    .dir_rd_o            (dir_rd_o),
    .dir_rd_set_o        (dir_rd_set_o),
    .dir_rd_gnt_i        (dir_rd_gnt_i),
    .dir_valid_i         (dir_valid_i),
    .dir_dirty_i         (dir_dirty_i),
    .dir_tag_i           (dir_tag_i),
    .dir_clr_dirty_o     (dir_clr_dirty_o),
    .dir_clr_set_o       (dir_clr_set_o),
    .dir_clr_way_o       (dir_clr_way_o),
    .flush_alloc_o       (flush_alloc_o),
    .flush_alloc_ready_i (flush_alloc_ready_i),
    .flush_alloc_nline_o (flush_alloc_nline_o),
    .flush_alloc_way_o   (flush_alloc_way_o),
    .flush_empty_i       (flush_empty_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int gnt_pct = 100, rdy_pct = 100, drain_pct = 100;
  int outstanding = 0;

  // Directory contents as seen by the walker.
  logic [WAYS-1:0] mem_valid [SETS];
  logic [WAYS-1:0] mem_dirty [SETS];
  logic [TW-1:0]   mem_tag   [SETS][WAYS];

  logic [NLW+WAYS-1:0] exp_q [$];
  int                  rd_q  [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Directory + flush-controller model.
  initial begin
    logic          hs;
    logic [SW-1:0] s;
    forever begin
      @(negedge clk_i);
      hs = rst_ni && dir_rd_o && dir_rd_gnt_i;
      s  = dir_rd_set_o;
      if (rst_ni && flush_alloc_o && flush_alloc_ready_i) outstanding++;
      if (rst_ni && dir_clr_dirty_o) begin
        for (int w = 0; w < int'(WAYS); w++)
          if (dir_clr_way_o[w]) mem_dirty[dir_clr_set_o][w] = 1'b0;
      end
      @(posedge clk_i);
      #1;
      if (outstanding > 0 && int'($urandom_range(99)) < drain_pct) outstanding--;
      flush_empty_i       = (outstanding == 0);
      dir_rd_gnt_i        = int'($urandom_range(99)) < gnt_pct;
      flush_alloc_ready_i = int'($urandom_range(99)) < rdy_pct;
      if (hs) begin
        dir_valid_i = mem_valid[s];
        dir_dirty_i = mem_dirty[s];
        for (int w = 0; w < int'(WAYS); w++) dir_tag_i[w*TW +: TW] = mem_tag[s][w];
      end else begin
        // Outside CHECK the walker must ignore the directory bus entirely.
        dir_valid_i = $urandom_range(1) ? '1 : WAYS'($urandom);
        dir_dirty_i = '1;
        dir_tag_i   = (WAYS*TW)'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transfer.
  initial begin
    logic                prev_alloc = 1'b0, prev_ready = 1'b0, prev_rd = 1'b0, prev_gnt = 1'b0;
    logic [NLW-1:0]      prev_nline = '0;
    logic [WAYS-1:0]     prev_way = '0;
    logic [SW-1:0]       prev_set = '0;
    logic [NLW+WAYS-1:0] e;
    int                  es;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_alloc = 1'b0;
        prev_rd    = 1'b0;
      end else begin
        if (prev_alloc && !prev_ready)
          chk("alloc_hold", {flush_alloc_o, flush_alloc_nline_o, flush_alloc_way_o},
              {1'b1, prev_nline, prev_way});
        if (prev_rd && !prev_gnt)
          chk("rd_hold", {dir_rd_o, dir_rd_set_o}, {1'b1, prev_set});
        chk("clr_only_on_handshake", dir_clr_dirty_o, flush_alloc_o & flush_alloc_ready_i);
        if (flush_alloc_o && flush_alloc_ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL alloc_unexpected: got nline %0h way %0h, required no ALLOC",
                     flush_alloc_nline_o, flush_alloc_way_o);
          end else begin
            e = exp_q.pop_front();
            chk("alloc_nline", flush_alloc_nline_o, e[WAYS +: NLW]);
            chk("alloc_way", flush_alloc_way_o, e[WAYS-1:0]);
            chk("clr_set", dir_clr_set_o, e[WAYS +: SW]);
            chk("clr_way", dir_clr_way_o, e[WAYS-1:0]);
          end
        end
        if (dir_rd_o && dir_rd_gnt_i) begin
          es = (rd_q.size() == 0) ? -1 : rd_q.pop_front();
          chk("rd_set_order", 64'(int'(dir_rd_set_o)), 64'(es));
        end
        if (flush_all_done_o) begin
          chk("done_allocs_all_seen", 64'(exp_q.size()), 0);
          chk("done_sets_all_read", 64'(rd_q.size()), 0);
          chk("done_while_empty", flush_empty_i, 1'b1);
          done_cnt++;
        end
        prev_alloc = flush_alloc_o;
        prev_ready = flush_alloc_ready_i;
        prev_nline = flush_alloc_nline_o;
        prev_way   = flush_alloc_way_o;
        prev_rd    = dir_rd_o;
        prev_gnt   = dir_rd_gnt_i;
        prev_set   = dir_rd_set_o;
      end
    end
  end

  // Reference model: every valid+dirty line, set order then ascending way.
  task automatic build_expect();
    for (int s = 0; s < int'(SETS); s++) begin
      rd_q.push_back(s);
      for (int w = 0; w < int'(WAYS); w++)
        if (mem_valid[s][w] && mem_dirty[s][w])
          exp_q.push_back({mem_tag[s][w], SW'(s), WAYS'(1) << w});
    end
  endtask

  task automatic clear_mem();
    for (int s = 0; s < int'(SETS); s++) begin
      mem_valid[s] = '0;
      mem_dirty[s] = '0;
      for (int w = 0; w < int'(WAYS); w++) mem_tag[s][w] = '0;
    end
  endtask

  task automatic random_mem();
    for (int s = 0; s < int'(SETS); s++) begin
      mem_valid[s] = WAYS'($urandom);
      mem_dirty[s] = WAYS'($urandom);
      for (int w = 0; w < int'(WAYS); w++) mem_tag[s][w] = TW'($urandom);
    end
  endtask

  task automatic pulse_req();
    @(posedge clk_i);
    #1 flush_all_req_i = 1'b1;
    @(posedge clk_i);
    #1 flush_all_req_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, flush_all_ready_o, 1'b1);
    chk({tag, "_outs"}, {flush_all_done_o, dir_rd_o, dir_rd_set_o, dir_clr_dirty_o,
                         dir_clr_set_o, dir_clr_way_o, flush_alloc_o, flush_alloc_nline_o,
                         flush_alloc_way_o}, '0);
  endtask

  task automatic run_flush(input int g, input int r, input int d, input bit poke,
                           input bit hold_ready);
    bit seen = 0;
    int poke_at = $urandom_range(2, 12);
    int hold_cnt = 0;
    build_expect();
    gnt_pct   = g;
    rdy_pct   = hold_ready ? 0 : r;
    drain_pct = d;
    done_cnt  = 0;
    pulse_req();
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk_i);
      flush_all_req_i = 1'b0;
      if (flush_all_done_o) seen = 1;
      else if (poke && i == poke_at && !flush_all_ready_o) flush_all_req_i = 1'b1;
      if (hold_ready && flush_alloc_o && hold_cnt < 3) begin
        hold_cnt++;
        if (hold_cnt == 3) rdy_pct = r;
      end
    end
    flush_all_req_i = 1'b0;
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL flush_timeout: got no done pulse, required one within 3000 cycles");
    end
    @(negedge clk_i);
    chk("ready_after_done", flush_all_ready_o, 1'b1);
    repeat (3) @(negedge clk_i);
    chk("single_done_pulse", 64'(done_cnt), 1);
    exp_q.delete();
    rd_q.delete();
  endtask

  initial begin
    rst_ni              = 1'b0;
    flush_all_req_i     = 1'b0;
    dir_rd_gnt_i        = 1'b1;
    dir_valid_i         = '0;
    dir_dirty_i         = '0;
    dir_tag_i           = '0;
    flush_alloc_ready_i = 1'b1;
    flush_empty_i       = 1'b1;
    clear_mem();
    repeat (2) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Clean walk timing: reads at cycles 1,3,5,7, done at 9, ready back at 10.
    build_expect();
    done_cnt = 0;
    @(posedge clk_i);
    #1 flush_all_req_i = 1'b1;
    @(posedge clk_i);
    #1 flush_all_req_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      chk($sformatf("clean_rd_c%0d", k), dir_rd_o, (k % 2 == 1) && (k <= 7));
      chk($sformatf("clean_done_c%0d", k), flush_all_done_o, k == 9);
      chk($sformatf("clean_ready_c%0d", k), flush_all_ready_o, k == 10);
      chk($sformatf("clean_alloc_c%0d", k), flush_alloc_o, 1'b0);
    end
    chk("clean_done_count", 64'(done_cnt), 1);
    exp_q.delete();
    rd_q.delete();

    // Single dirty line; the flush controller drains slowly.
    clear_mem();
    mem_valid[2] = 2'b10;
    mem_dirty[2] = 2'b10;
    mem_tag[2][1] = 8'h5A;
    run_flush(100, 100, 15, 0, 0);
    chk("line_cleared", mem_dirty[2], 2'b00);

    // Both ways of set 0 dirty with backpressure on the first.
    clear_mem();
    mem_valid[0] = 2'b11;
    mem_dirty[0] = 2'b11;
    mem_tag[0][0] = 8'h11;
    mem_tag[0][1] = 8'h22;
    run_flush(100, 100, 100, 0, 1);

    // Grant starvation and mid-walk request pokes on random contents.
    for (int n = 0; n < 8; n++) begin
      random_mem();
      run_flush(int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
                int'($urandom_range(10, 100)), 1, 0);
      // Everything flushed: a second pass must find nothing dirty and valid.
      run_flush(60, 60, 100, 0, 0);
    end

    // Reset while EMIT is stalled, then restart from set 0.
    clear_mem();
    mem_valid[0] = 2'b11;
    mem_dirty[0] = 2'b11;
    mem_tag[0][0] = 8'h33;
    mem_tag[0][1] = 8'h44;
    rd_q.push_back(0);
    gnt_pct = 100;
    rdy_pct = 0;
    drain_pct = 100;
    pulse_req();
    for (int i = 0; i < 50 && !flush_alloc_o; i++) @(negedge clk_i);
    chk("emit_reached", flush_alloc_o, 1'b1);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1 check_reset_outputs("async_reset");
    rd_q.delete();
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_flush(100, 100, 100, 0, 0);
    chk("restart_cleared", mem_dirty[0], 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hpdcache_flush_walker.md
# hpdcache_flush_walker

Flush-all sequencer that walks every set of the HPDcache directory and hands each valid, dirty line to the flush controller's ALLOC interface. It clears each line's dirty bit as the line is accepted. After the last set it waits for the flush controller to drain, then signals completion. It sits between the cache controller (flush-all request, shared directory port) and the flush controller (ALLOC handshake, empty status).

## Interface
- SETS, 64, number of cache sets (≥1); SetWidth = max(1, $clog2(SETS))
- WAYS, 4, number of ways (≥1)
- TAG_WIDTH, 20, directory tag width; nline = {tag, set}, width TAG_WIDTH+SetWidth
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_all_req_i  in  1  start a full-cache flush
- flush_all_ready_o  out  1  walker idle; a request is accepted when req & ready
- flush_all_done_o  out  1  one-cycle pulse: walk finished and flush controller empty
- dir_rd_o  out  1  directory read request for all ways of one set
- dir_rd_set_o  out  SetWidth  set to read
- dir_rd_gnt_i  in  1  directory port granted this cycle
- dir_valid_i  in  WAYS  per-way valid, returned the cycle after grant
- dir_dirty_i  in  WAYS  per-way dirty, returned the cycle after grant
- dir_tag_i  in  WAYS*TAG_WIDTH  per-way tags, way w at [w*TAG_WIDTH +: TAG_WIDTH]
- dir_clr_dirty_o  out  1  clear the dirty bit of one line
- dir_clr_set_o  out  SetWidth  set of the line to clear
- dir_clr_way_o  out  WAYS  one-hot way of the line to clear
- flush_alloc_o  out  1  ALLOC valid to the flush controller
- flush_alloc_ready_i  in  1  ALLOC ready from the flush controller
- flush_alloc_nline_o  out  TAG_WIDTH+SetWidth  line address
- flush_alloc_way_o  out  WAYS  one-hot way
- flush_empty_i  in  1  flush controller has no outstanding entries

## Operation
- States: IDLE, READ, CHECK, EMIT, DRAIN. Registers:
  - set_cnt (SetWidth)
  - pending (WAYS)
  - tags (WAYS*TAG_WIDTH)
- IDLE: flush_all_ready_o=1. On flush_all_req_i, set set_cnt=0 and go to READ.
- READ: dir_rd_o=1, dir_rd_set_o=set_cnt. On dir_rd_gnt_i go to CHECK; otherwise hold with the set stable.
- CHECK: capture pending=dir_valid_i&dir_dirty_i and capture tags.
  - If pending≠0, go to EMIT.
  - Otherwise advance (see below).
- EMIT: sel = lowest set bit of pending.
  - Drive flush_alloc_o=1, flush_alloc_nline_o={tags[sel],set_cnt}, flush_alloc_way_o=onehot(sel).
  - On flush_alloc_ready_i: in the same cycle assert dir_clr_dirty_o with set_cnt and onehot(sel), and clear pending[sel].
  - If pending had a single bit, advance; else stay in EMIT.
- Advance: if set_cnt==SETS-1, go to DRAIN; else set_cnt+1 and go to READ. There is no wrap past SETS-1.
- DRAIN: flush_all_done_o = flush_empty_i. When flush_empty_i=1, go to IDLE.
- While flush_alloc_o=1, nline and way stay stable until ready (valid never retracts).
- flush_all_req_i outside IDLE is ignored; ready_o=0.
- dir_clr_dirty_o is asserted only on an ALLOC handshake, for exactly one cycle per line.
- Reset mid-walk: immediately go to IDLE, clear all registers, emit no done pulse. Lines already accepted stay with the flush controller.

## Timing
- Reset values:
  - flush_all_ready_o=1
  - all other outputs 0 (dir_rd_set_o, dir_clr_*, flush_alloc_nline_o, flush_alloc_way_o = '0)
- Accept at cycle T gives READ at T+1.
- Clean set with the grant held high: 2 cycles (READ, CHECK).
- Each dirty line: 1 cycle in EMIT if ready=1, plus backpressure cycles.
- Full clean walk with the grant always high: DRAIN is entered at T+1+2·SETS.
- done asserts combinationally in the first DRAIN cycle with flush_empty_i=1, and ready_o rises the next cycle.
- Directory data is sampled only in CHECK (1-cycle read latency after grant). Inputs in other cycles are don't-care.

## Test plan
- SETS=4, WAYS=2, all lines clean, grant=1, empty=1, req at cycle 0 -> dir_rd_o for sets 0,1,2,3 at cycles 1,3,5,7; no flush_alloc_o; done pulse at cycle 9; ready_o=1 at cycle 10.
- Set 2, way 1 valid+dirty with tag 0x5A -> one ALLOC with nline={0x5A,2'd2} and way=2'b10; dir_clr_dirty_o set=2, way=2'b10 in the same cycle; done only after flush_empty_i rises.
- Set 0 with both ways dirty (tags 0x11, 0x22), ready low for 3 cycles -> way0/0x11 held stable for 4 cycles, then way1/0x22 in the next cycle; exactly 2 clear pulses.
- dir_rd_gnt_i low for 5 cycles in set 1 -> dir_rd_o and dir_rd_set_o=1 held; CHECK occurs only after the grant; valid/dirty driven high in non-CHECK cycles is ignored.
- flush_all_req_i pulsed mid-walk -> ignored, a single done pulse.
- rst_ni asserted in EMIT with ready low -> all outputs reach reset values asynchronously; the next req starts at set 0.
